// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants, FSM encoding and digit helpers for the 7-segment scanner
//
// Purpose: anode patterns, scan FSM state type, BCD digit width, and small
// helpers for digit extraction and leading-zero blanking.
// Ports: none (package).

package seg_disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [3:0] ANODE_DIG0 = 4'b1110;
  localparam logic [3:0] ANODE_DIG1 = 4'b1101;
  localparam logic [3:0] ANODE_DIG2 = 4'b1011;
  localparam logic [3:0] ANODE_DIG3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_t;

  function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return ANODE_DIG0;
      2'd1:    return ANODE_DIG1;
      2'd2:    return ANODE_DIG2;
      default: return ANODE_DIG3;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] digit_of(input logic [15:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[3:0];
      2'd1:    return word[7:4];
      2'd2:    return word[11:8];
      default: return word[15:12];
    endcase
  endfunction

  // A digit is blanked when it and every more-significant digit are zero;
  // digit0 is always shown so a zero word still displays "0".
  function automatic logic digit_blanked(input logic [15:0] word, input logic [1:0] idx,
                                         input logic lz_en);
    logic z3, z2, z1;
    z3 = (word[15:12] == 4'd0);
    z2 = (word[11:8] == 4'd0);
    z1 = (word[7:4] == 4'd0);
    case (idx)
      2'd3:    return lz_en && z3;
      2'd2:    return lz_en && z3 && z2;
      2'd1:    return lz_en && z3 && z2 && z1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_load_buffer.sv
// rtl/seg_load_buffer.sv - valid/ready shadow buffer feeding the active display word
//
// Purpose: holds one pending display word and moves it into the active word
// on commit (frame boundary) or flush (display disabled).
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   load_valid, load_data   incoming word, accepted when load_ready is high
//   load_ready              high while no word is pending
//   commit                  frame boundary; pending word becomes active
//   flush                   display disabled; pending word becomes active
//   active_word             word currently being scanned
//   next_word               word that will be active after a commit this cycle

module seg_load_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        commit,
  input  logic        flush,
  output logic [15:0] active_word,
  output logic [15:0] next_word
);

  logic [15:0] shadow_word;
  logic        pending;

  assign load_ready = ~pending;
  assign next_word  = pending ? shadow_word : active_word;

  // Commit only moves a word when one is pending, and a load is only taken
  // when nothing is pending, so the two branches never compete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_word <= 16'd0;
      shadow_word <= 16'd0;
      pending     <= 1'b0;
    end else if ((commit || flush) && pending) begin
      active_word <= shadow_word;
      pending     <= 1'b0;
    end else if (load_valid && !pending) begin
      shadow_word <= load_data;
      pending     <= 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - 4-digit multiplexed 7-segment scan controller
//
// Purpose: scans a 16-bit BCD word over four active-low anodes with a
// dead-time guard before each digit, brightness duty, leading-zero blanking
// and tear-free word updates at frame boundaries.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   disp_en                 1 = scanning, 0 = display off
//   lz_en                   leading-zero blanking enable
//   brightness              duty level, 15 = full on
//   load_valid, load_data   new BCD word ([3:0] = digit0)
//   load_ready              new word can be accepted
//   seg_anode               active-low anode select
//   bcd_val                 BCD nibble of the current digit
//   frame_done              one-cycle pulse at the start of each new frame

module seg_scan_scheduler
  import seg_disp_pkg::*;
#(
  parameter int DWELL_W     = 10,
  parameter int DEAD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_en,
  input  logic             lz_en,
  input  logic [3:0]       brightness,
  input  logic             load_valid,
  input  logic [15:0]      load_data,
  output logic             load_ready,
  output logic [3:0]       seg_anode,
  output logic [BCD_W-1:0] bcd_val,
  output logic             frame_done
);

  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = '1;

  scan_state_t        state;
  logic [1:0]         idx;
  logic [DEAD_W-1:0]  dead_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [3:0]         bri_q;

  logic [15:0]        active_word;
  logic [15:0]        next_word;
  logic               commit;
  logic               blanked;
  logic [DWELL_W-1:0] dwell_nxt;

  assign commit    = disp_en && (state == ST_ON) && (dwell_cnt == DWELL_LAST) && (idx == 2'd3);
  assign blanked   = digit_blanked(active_word, idx, lz_en);
  assign dwell_nxt = dwell_cnt + 1'b1;

  seg_load_buffer u_load_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .commit      (commit),
    .flush       (~disp_en),
    .active_word (active_word),
    .next_word   (next_word)
  );

  // Anode is registered, so each branch computes the anode for the cycle
  // that follows; the duty test uses the top four bits of the dwell count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      dead_cnt   <= '0;
      dwell_cnt  <= '0;
      bri_q      <= 4'd0;
      seg_anode  <= ANODE_OFF;
      bcd_val    <= '0;
      frame_done <= 1'b0;
    end else if (!disp_en) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      dead_cnt   <= '0;
      dwell_cnt  <= '0;
      seg_anode  <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          state     <= ST_BLANK;
          idx       <= 2'd0;
          dead_cnt  <= '0;
          bcd_val   <= digit_of(active_word, 2'd0);
          seg_anode <= ANODE_OFF;
        end
        ST_BLANK: begin
          if (dead_cnt == DEAD_LAST) begin
            state     <= ST_ON;
            dead_cnt  <= '0;
            dwell_cnt <= '0;
            bri_q     <= brightness;
            // Dwell count 0 is inside every duty window.
            seg_anode <= blanked ? ANODE_OFF : anode_pattern(idx);
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (dwell_cnt == DWELL_LAST) begin
            state      <= ST_BLANK;
            idx        <= idx + 2'd1;
            dwell_cnt  <= '0;
            seg_anode  <= ANODE_OFF;
            // On wrap, digit0 comes from the word being committed this edge.
            bcd_val    <= (idx == 2'd3) ? digit_of(next_word, 2'd0)
                                        : digit_of(active_word, idx + 2'd1);
            frame_done <= (idx == 2'd3);
          end else begin
            dwell_cnt <= dwell_nxt;
            seg_anode <= (!blanked && (dwell_nxt[DWELL_W-1 -: 4] <= bri_q))
                         ? anode_pattern(idx) : ANODE_OFF;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - self-checking bench for seg_scan_scheduler

module tb_seg_scan_scheduler;

  localparam int DWELL_W = 4;
  localparam int DEAD    = 2;
  localparam int DWELL   = 16;
  localparam int SLOT    = DEAD + DWELL;
  localparam int FRAME   = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_en;
  logic        lz_en;
  logic [3:0]  brightness;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  seg_anode;
  logic [3:0]  bcd_val;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_scheduler #(.DWELL_W(DWELL_W), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_en    (disp_en),
    .lz_en      (lz_en),
    .brightness (brightness),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .seg_anode  (seg_anode),
    .bcd_val    (bcd_val),
    .frame_done (frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int s);
    logic [15:0] x;
    x = w >> (4 * s);
    return x[3:0];
  endfunction

  function automatic logic [3:0] pat(input int s);
    logic [3:0] p;
    p = 4'b1111;
    p[s] = 1'b0;
    return p;
  endfunction

  function automatic logic lzb(input logic [15:0] w, input int s, input logic lz);
    if (!lz || s == 0) return 1'b0;
    for (int d = s; d < 4; d++)
      if (nib(w, d) != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Model: time since scanning began, split into frame/slot/position.
  logic        m_ok = 1'b0;
  logic        m_scan;
  int          m_t;
  logic [15:0] m_active, m_shadow;
  logic        m_pending;
  logic [3:0]  m_bri;
  logic [3:0]  e_anode, e_bcd;
  logic        e_fd, e_ready;

  always @(posedge clk) begin
    logic [15:0] na, nsh;
    logic        np;
    int          slot, pos;
    if (!rst_n) begin
      m_active = 16'd0; m_shadow = 16'd0; m_pending = 1'b0;
      m_scan = 1'b0; m_t = 0; m_bri = 4'd0;
      e_anode = 4'hF; e_bcd = 4'd0; e_fd = 1'b0;
    end else begin
      na = m_active; nsh = m_shadow; np = m_pending;
      if (m_pending && (!disp_en || (m_scan && (m_t % FRAME == FRAME - 1)))) begin
        na = m_shadow; np = 1'b0;
      end else if (load_valid && !m_pending) begin
        nsh = load_data; np = 1'b1;
      end
      if (!disp_en) begin
        m_scan = 1'b0; e_anode = 4'hF; e_fd = 1'b0;
      end else begin
        if (m_scan) m_t++;
        else begin m_scan = 1'b1; m_t = 0; end
        slot = (m_t / SLOT) % 4;
        pos  = m_t % SLOT;
        if (pos == 0) e_bcd = nib(na, slot);
        if (pos == DEAD) m_bri = brightness;
        if (pos < DEAD) e_anode = 4'hF;
        else e_anode = (!lzb(na, slot, lz_en) && (pos - DEAD) <= int'(m_bri)) ? pat(slot) : 4'hF;
        e_fd = (m_t > 0) && (m_t % FRAME == 0);
      end
      m_active = na; m_shadow = nsh; m_pending = np;
    end
    e_ready = !m_pending;
    m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("anode", {12'd0, seg_anode}, {12'd0, e_anode});
      chk("bcd", {12'd0, bcd_val}, {12'd0, e_bcd});
      chk("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
      chk("load_ready", {15'd0, load_ready}, {15'd0, e_ready});
    end
  end

  int cur;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic adv(input int t);
    tick(t - cur);
    cur = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; disp_en = 1'b0; lz_en = 1'b0; brightness = 4'd15;
    load_valid = 1'b0; load_data = 16'd0;
    tick(3);
    chk("rst_anode", {12'd0, seg_anode}, 16'h000F);
    chk("rst_bcd", {12'd0, bcd_val}, 16'h0000);
    chk("rst_ready", {15'd0, load_ready}, 16'h0001);

    // 1: first frame shows 0000, 1234 commits at the boundary
    rst_n = 1'b1; disp_en = 1'b1; load_valid = 1'b1; load_data = 16'h1234; cur = -1;
    adv(0); load_valid = 1'b0;
    chk("t1_t0_anode", {12'd0, seg_anode}, 16'h000F);
    chk("t1_t0_ready", {15'd0, load_ready}, 16'h0000);
    adv(2);   chk("t1_d0_anode", {12'd0, seg_anode}, 16'h000E);
    adv(71);  chk("t1_d3_anode", {12'd0, seg_anode}, 16'h0007);
              chk("t1_pre_ready", {15'd0, load_ready}, 16'h0000);
    adv(72);  chk("t1_fd", {15'd0, frame_done}, 16'h0001);
              chk("t1_bcd0", {12'd0, bcd_val}, 16'h0004);
    adv(74);  chk("t1_f1_d0", {12'd0, seg_anode}, 16'h000E);
    adv(92);  chk("t1_f1_d1", {12'd0, seg_anode}, 16'h000D);
              chk("t1_bcd1", {12'd0, bcd_val}, 16'h0003);
    adv(128); chk("t1_f1_d3", {12'd0, seg_anode}, 16'h0007);
              chk("t1_bcd3", {12'd0, bcd_val}, 16'h0001);

    // 2: brightness 3 gives 4 of 16 on cycles
    brightness = 4'd3; load_valid = 1'b1; load_data = 16'h5678;
    adv(129); load_valid = 1'b0;
    adv(146); chk("t2_on0", {12'd0, seg_anode}, 16'h000E);
              chk("t2_bcd", {12'd0, bcd_val}, 16'h0008);
    adv(149); chk("t2_on3", {12'd0, seg_anode}, 16'h000E);
    adv(150); chk("t2_off4", {12'd0, seg_anode}, 16'h000F);
    adv(161); chk("t2_off15", {12'd0, seg_anode}, 16'h000F);
    adv(164); chk("t2_d1", {12'd0, seg_anode}, 16'h000D);

    // 3: leading-zero blanking of 0040
    adv(170); lz_en = 1'b1; brightness = 4'd15; load_valid = 1'b1; load_data = 16'h0040;
    adv(171); load_valid = 1'b0;
    adv(218); chk("t3_d0", {12'd0, seg_anode}, 16'h000E);
    adv(236); chk("t3_d1", {12'd0, seg_anode}, 16'h000D);
              chk("t3_bcd1", {12'd0, bcd_val}, 16'h0004);
    adv(254); chk("t3_d2_blank", {12'd0, seg_anode}, 16'h000F);
    adv(272); chk("t3_d3_blank", {12'd0, seg_anode}, 16'h000F);
    adv(288); chk("t3_fd", {15'd0, frame_done}, 16'h0001);

    // 4: second load while not ready is ignored
    adv(290); load_valid = 1'b1; load_data = 16'hAAAA;
    adv(291); chk("t4_busy", {15'd0, load_ready}, 16'h0000);
              load_data = 16'hBBBB;
    adv(295); load_valid = 1'b0;
    adv(359); chk("t4_ready_lo", {15'd0, load_ready}, 16'h0000);
    adv(361); chk("t4_ready_hi", {15'd0, load_ready}, 16'h0001);
    adv(362); chk("t4_bcd0", {12'd0, bcd_val}, 16'h000A);
    adv(416); chk("t4_bcd3", {12'd0, bcd_val}, 16'h000A);
              chk("t4_d3", {12'd0, seg_anode}, 16'h0007);

    // 5: disable mid digit2, flush a load while off, restart
    adv(475); disp_en = 1'b0;
    adv(476); chk("t5_off", {12'd0, seg_anode}, 16'h000F);
              load_valid = 1'b1; load_data = 16'h0007;
    adv(477); load_valid = 1'b0;
              chk("t5_pend", {15'd0, load_ready}, 16'h0000);
    adv(478); chk("t5_flushed", {15'd0, load_ready}, 16'h0001);
    adv(480); disp_en = 1'b1; cur = -1;
    adv(0);   chk("t5_restart", {12'd0, seg_anode}, 16'h000F);
              chk("t5_bcd", {12'd0, bcd_val}, 16'h0007);
    adv(2);   chk("t5_d0", {12'd0, seg_anode}, 16'h000E);
    adv(20);  chk("t5_d1_blank", {12'd0, seg_anode}, 16'h000F);

    // 6: reset during digit1 ON discards a pending load
    adv(21); load_valid = 1'b1; load_data = 16'h9999;
    adv(22); load_valid = 1'b0;
             chk("t6_pend", {15'd0, load_ready}, 16'h0000);
    adv(25); rst_n = 1'b0;
    adv(26); chk("t6_rst_anode", {12'd0, seg_anode}, 16'h000F);
             chk("t6_rst_bcd", {12'd0, bcd_val}, 16'h0000);
             chk("t6_rst_ready", {15'd0, load_ready}, 16'h0001);
    adv(28); rst_n = 1'b1; cur = -1;
    adv(0);   chk("t6_bcd0", {12'd0, bcd_val}, 16'h0000);
    adv(72);  chk("t6_fd", {15'd0, frame_done}, 16'h0001);
              chk("t6_bcd_f1", {12'd0, bcd_val}, 16'h0000);
    adv(150);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
